// File: rtl/seg_display_pkg.sv
// Shared constants, segment decoder and converter state encoding for the
// multiplexed common-anode 7-segment controller.
package seg_display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_t;

   // Active-low {g..a} pattern for one BCD digit; non-decimal codes go dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = SEG_BLANK;
      endcase
      return pattern;
   endfunction

   // Double-dabble correction applied to a nibble before each shift.
   function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
      logic [3:0] adj;
      if (nib >= 4'd5) begin
         adj = nib + 4'd3;
      end else begin
         adj = nib;
      end
      return adj;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble) behind a valid/ready load.
// One add-3-then-shift step per cycle; result is presented for one commit cycle.
module bin2bcd_seq
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int VAL_W      = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    value_valid,
   input  logic [VAL_W-1:0]        value,
   output logic                    value_ready,
   output logic [4*NUM_DIGITS-1:0] bcd,
   output logic                    ovf,
   output logic                    commit
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VAL_W - 1);
   localparam int unsigned MAX_INT = 10 ** NUM_DIGITS - 1;
   localparam logic [VAL_W:0] MAX_VAL = (VAL_W + 1)'(MAX_INT);

   conv_state_t        state_r;
   conv_state_t        state_s;
   logic [VAL_W-1:0]   shift_r;
   logic [BCD_W-1:0]   bcd_r;
   logic [BCD_W-1:0]   bcd_adj_s;
   logic [CNT_W-1:0]   cnt_r;
   logic               ovf_r;
   logic               ready_r;
   logic               accept_s;

   assign accept_s = value_valid & ready_r;

   // Next-state logic for the IDLE/SHIFT/COMMIT sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = ST_SHIFT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == CNT_LAST) begin
               state_s = ST_COMMIT;
            end else begin
               state_s = ST_SHIFT;
            end
         end
         ST_COMMIT: state_s = ST_IDLE;
         default:   state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Per-nibble add-3 correction on the current BCD accumulator.
   always_comb begin
      bcd_adj_s = bcd_r;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         bcd_adj_s[4*i +: 4] = bcd_add3(bcd_r[4*i +: 4]);
      end
   end

   // Conversion datapath: latch on accept, shift VAL_W times, reopen after commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= '0;
         bcd_r   <= '0;
         cnt_r   <= '0;
         ovf_r   <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  shift_r <= value;
                  bcd_r   <= '0;
                  cnt_r   <= '0;
                  ovf_r   <= ({1'b0, value} > MAX_VAL);
                  ready_r <= 1'b0;
               end
            end
            ST_SHIFT: begin
               bcd_r   <= {bcd_adj_s[BCD_W-2:0], shift_r[VAL_W-1]};
               shift_r <= {shift_r[VAL_W-2:0], 1'b0};
               cnt_r   <= cnt_r + CNT_W'(1);
            end
            ST_COMMIT: ready_r <= 1'b1;
            default:   ready_r <= 1'b1;
         endcase
      end
   end

   assign value_ready = ready_r;
   assign bcd         = bcd_r;
   assign ovf         = ovf_r;
   assign commit      = (state_r == ST_COMMIT);

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit multiplexed 7-segment controller: sequential BCD conversion, digit scan,
// blink, decimal points, leading-zero blanking and overflow dashes. Outputs registered.
module seg_display_ctrl
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int VAL_W       = 14,
   parameter int REFRESH_DIV = 50_000,
   parameter int BLINK_DIV   = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  value_valid,
   input  logic [VAL_W-1:0]      value,
   output logic                  value_ready,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   input  logic                  blank_lz_en,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  overflow
);

   localparam int BCD_W = 4 * NUM_DIGITS;
   localparam int REF_W = $clog2(REFRESH_DIV);
   localparam int BLK_W = $clog2(BLINK_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [REF_W-1:0] REF_TC   = REF_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_TC   = BLK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [BCD_W-1:0]      conv_bcd_s;
   logic                  conv_ovf_s;
   logic                  conv_commit_s;
   logic [BCD_W-1:0]      disp_bcd_r;
   logic                  overflow_r;
   logic [REF_W-1:0]      ref_cnt_r;
   logic [IDX_W-1:0]      idx_r;
   logic [BLK_W-1:0]      blink_cnt_r;
   logic                  blink_phase_r;
   logic [NUM_DIGITS-1:0] slot_sel_s;
   logic [NUM_DIGITS-1:0] zero_above_s;
   logic [3:0]            cur_digit_s;
   logic                  cur_blink_s;
   logic                  cur_dp_s;
   logic                  cur_zero_s;
   logic [6:0]            seg_s;
   logic                  dp_s;
   logic [6:0]            seg_r;
   logic                  dp_r;
   logic [NUM_DIGITS-1:0] an_r;

   bin2bcd_seq #(
      .NUM_DIGITS (NUM_DIGITS),
      .VAL_W      (VAL_W)
   ) u_conv (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_valid (value_valid),
      .value       (value),
      .value_ready (value_ready),
      .bcd         (conv_bcd_s),
      .ovf         (conv_ovf_s),
      .commit      (conv_commit_s)
   );

   // Displayed value changes only on a completed conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_bcd_r <= '0;
         overflow_r <= 1'b0;
      end else if (conv_commit_s) begin
         disp_bcd_r <= conv_bcd_s;
         overflow_r <= conv_ovf_s;
      end
   end

   // Refresh counter and digit-slot index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt_r <= '0;
         idx_r     <= '0;
      end else if (ref_cnt_r == REF_TC) begin
         ref_cnt_r <= '0;
         idx_r     <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
      end else begin
         ref_cnt_r <= ref_cnt_r + REF_W'(1);
      end
   end

   // Blink timebase; parked in the lit phase while nothing blinks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b1;
      end else if (|blink_mask) begin
         if (blink_cnt_r == BLK_TC) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
         end else begin
            blink_cnt_r   <= blink_cnt_r + BLK_W'(1);
         end
      end else begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b1;
      end
   end

   // zero_above_s[g]: digit g and every more significant digit are zero.
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
      assign slot_sel_s[g]   = (idx_r == IDX_W'(g));
      assign zero_above_s[g] = (disp_bcd_r[BCD_W-1:4*g] == '0);
   end

   // AND-OR select of the per-slot attributes for the active digit.
   always_comb begin
      cur_digit_s = 4'd0;
      cur_blink_s = 1'b0;
      cur_dp_s    = 1'b0;
      cur_zero_s  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         cur_digit_s = cur_digit_s | (disp_bcd_r[4*i +: 4] & {4{slot_sel_s[i]}});
         cur_blink_s = cur_blink_s | (blink_mask[i] & slot_sel_s[i]);
         cur_dp_s    = cur_dp_s | (dp_mask[i] & slot_sel_s[i]);
         cur_zero_s  = cur_zero_s | (zero_above_s[i] & slot_sel_s[i]);
      end
   end

   // Priority: overflow dash, blink-off, leading-zero blank, then decoded digit.
   always_comb begin
      seg_s = SEG_BLANK;
      dp_s  = 1'b1;
      if (overflow_r) begin
         seg_s = SEG_DASH;
         dp_s  = 1'b1;
      end else if (cur_blink_s && !blink_phase_r) begin
         seg_s = SEG_BLANK;
         dp_s  = 1'b1;
      end else if (blank_lz_en && (idx_r != '0) && cur_zero_s) begin
         seg_s = SEG_BLANK;
         dp_s  = ~cur_dp_s;
      end else begin
         seg_s = seg_decode(cur_digit_s);
         dp_s  = ~cur_dp_s;
      end
   end

   // Pin registers; everything dark in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_r <= SEG_BLANK;
         dp_r  <= 1'b1;
         an_r  <= '1;
      end else begin
         seg_r <= seg_s;
         dp_r  <= dp_s;
         an_r  <= ~slot_sel_s;
      end
   end

   assign seg      = seg_r;
   assign dp       = dp_r;
   assign an       = an_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized self-checking bench for seg_display_ctrl against a cycle-level
// behavioural model that works on the decimal value with integer arithmetic.
module tb_seg_display_ctrl;

   localparam int ND = 4;
   localparam int VW = 14;
   localparam int RD = 4;
   localparam int BD = 8;
   localparam logic [6:0] DEC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};
   localparam int P10 [5] = '{1, 10, 100, 1000, 10000};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          value_valid;
   logic [VW-1:0] value;
   logic          value_ready;
   logic [ND-1:0] blink_mask;
   logic [ND-1:0] dp_mask;
   logic          blank_lz_en;
   logic [6:0]    seg;
   logic          dp;
   logic [ND-1:0] an;
   logic          overflow;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int         m_busy, m_pend, m_disp, m_ref, m_idx, m_bcnt;
   logic       m_ovf, m_phase, m_ready, m_dp;
   logic [6:0] m_seg;
   logic [3:0] m_an;

   seg_display_ctrl #(
      .NUM_DIGITS (ND),
      .VAL_W      (VW),
      .REFRESH_DIV(RD),
      .BLINK_DIV  (BD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_valid (value_valid),
      .value       (value),
      .value_ready (value_ready),
      .blink_mask  (blink_mask),
      .dp_mask     (dp_mask),
      .blank_lz_en (blank_lz_en),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin : model
      int d;
      if (!rst_n) begin
         m_busy = 0; m_pend = 0; m_disp = 0; m_ref = 0; m_idx = 0; m_bcnt = 0;
         m_ovf = 1'b0; m_phase = 1'b1; m_ready = 1'b1;
         m_seg = 7'h7F; m_dp = 1'b1; m_an = 4'hF;
      end else begin
         d = (m_disp / P10[m_idx]) % 10;
         m_an = ~(4'b0001 << m_idx);
         if (m_ovf) begin
            m_seg = 7'b0111111; m_dp = 1'b1;
         end else if (blink_mask[m_idx] && !m_phase) begin
            m_seg = 7'h7F; m_dp = 1'b1;
         end else if (blank_lz_en && m_idx > 0 && m_disp < P10[m_idx]) begin
            m_seg = 7'h7F; m_dp = ~dp_mask[m_idx];
         end else begin
            m_seg = DEC[d]; m_dp = ~dp_mask[m_idx];
         end
         if (m_busy == 0) begin
            if (value_valid) begin
               m_pend = int'(value); m_busy = VW + 1; m_ready = 1'b0;
            end
         end else begin
            m_busy = m_busy - 1;
            if (m_busy == 0) begin
               m_disp = m_pend; m_ovf = (m_pend > P10[ND] - 1); m_ready = 1'b1;
            end
         end
         if (m_ref == RD - 1) begin
            m_ref = 0; m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
         end else begin
            m_ref = m_ref + 1;
         end
         if (blink_mask != 0) begin
            if (m_bcnt == BD - 1) begin
               m_bcnt = 0; m_phase = ~m_phase;
            end else begin
               m_bcnt = m_bcnt + 1;
            end
         end else begin
            m_bcnt = 0; m_phase = 1'b1;
         end
      end
   end

   task automatic test_reset();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL reset_run t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({seg, dp, an, value_ready, overflow} !== {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_async got=%b want=%b", {seg, dp, an, value_ready, overflow},
                  {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_load_scan();
      int low = 0;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL load_scan t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
         if (!value_ready) low++;
         value_valid = (c == 0);
         value = 14'd1234;
      end
      n_tests++;
      if (low !== 15) begin
         n_fail++;
         $display("FAIL ready_low_cycles got=%0d want=15", low);
      end
   endtask

   task automatic test_blank();
      blank_lz_en = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL blank_lz t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
         value_valid = (c == 0);
         value = 14'd7;
         if (c == 40) blank_lz_en = 1'b0;
      end
   endtask

   task automatic test_overflow();
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL overflow t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
         if (c == 25) begin
            n_tests++;
            if ({overflow, seg} !== {1'b1, 7'b0111111}) begin
               n_fail++;
               $display("FAIL overflow_dash got=%b want=%b", {overflow, seg}, {1'b1, 7'b0111111});
            end
         end
         value_valid = (c == 0) || (c == 30);
         value = (c < 30) ? 14'd10000 : 14'd42;
      end
      n_tests++;
      if (overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear got=%b want=0", overflow);
      end
   endtask

   task automatic test_blink_dp();
      blink_mask = 4'b0001;
      dp_mask = 4'b0100;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL blink_dp t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
         value_valid = (c == 0);
         value = 14'd1234;
      end
      blink_mask = 4'b0000;
      dp_mask = 4'b0000;
   endtask

   task automatic test_busy_abort();
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL busy_ignore t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
         value_valid = (c == 0) || (c >= 3 && c <= 7) || (c == 30);
         value = (c == 0) ? 14'd1234 : (c == 30) ? 14'd4321 : 14'd5678;
         if (c == 35) break;
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({seg, dp, an, value_ready, overflow} !== {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL abort_reset got=%b want=%b", {seg, dp, an, value_ready, overflow},
                  {7'h7F, 1'b1, 4'hF, 1'b1, 1'b0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL abort_after t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         n_tests++;
         if ({seg, dp, an, value_ready, overflow} !== {m_seg, m_dp, m_an, m_ready, m_ovf}) begin
            n_fail++;
            $display("FAIL random t=%0t got=%b want=%b (seg,dp,an,ready,ovf)", $time,
                     {seg, dp, an, value_ready, overflow}, {m_seg, m_dp, m_an, m_ready, m_ovf});
         end
         value_valid = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 3))
            0:       value = 14'($urandom_range(0, 99));
            1:       value = 14'($urandom_range(0, 9999));
            2:       value = 14'($urandom_range(9990, 10010));
            default: value = 14'($urandom_range(0, 16383));
         endcase
         if ($urandom_range(0, 99) == 0) blink_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) dp_mask = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) blank_lz_en = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      value_valid = 1'b0;
      value = 14'd0;
      blink_mask = 4'b0000;
      dp_mask = 4'b0000;
      blank_lz_en = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_load_scan();
      test_blank();
      test_overflow();
      test_blink_dp();
      test_busy_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
